systolic_feed_ctrl: RTL and testbench

SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

---
 rtl/systolic_feed_ctrl_pkg.sv | 30 +++
 rtl/systolic_feed_ctrl_if.sv | 37 +++
 rtl/systolic_feed_ctrl_lane_skew.sv | 27 ++
 rtl/systolic_feed_ctrl.sv | 141 ++++++++++++++
 tb/tb_systolic_feed_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared types for the systolic feed controller: FSM encoding and
// counter-width helpers derived from the array geometry.
package systolic_feed_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Never return a zero width, so degenerate N=1 / M=1 still elaborate.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int row_w(input int m);
        return cnt_w(m);
    endfunction

    function automatic int col_w(input int n);
        return cnt_w(n);
    endfunction

    function automatic int drn_w(input int n);
        return cnt_w(n + 1);
    endfunction

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Upstream stream, buffer port and lane-feed bundle of the controller.
interface systolic_feed_ctrl_if
    import systolic_feed_ctrl_pkg::*;
#(
    parameter int D_2_W = 32,
    parameter int N     = 4,
    parameter int M     = 7
);
    localparam int RW = row_w(M);
    localparam int CW = col_w(N);

    logic             start;
    logic             in_valid;
    logic [D_2_W-1:0] in_data;
    logic             in_ready;
    logic             buf_we;
    logic [D_2_W-1:0] buf_wdata;
    logic [RW-1:0]    buf_row;
    logic [CW-1:0]    buf_col;
    logic             buf_re;
    logic [N-1:0]     lane_en;
    logic             busy;
    logic             done;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, buf_we, buf_wdata, buf_row, buf_col,
        input  buf_re, lane_en, busy, done
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, buf_we, buf_wdata, buf_row, buf_col,
        output buf_re, lane_en, busy, done
    );

endinterface

// File: rtl/systolic_feed_ctrl_lane_skew.sv
// Diagonal skew for the array: lane j sees the row-read strobe
// one buffer-latency cycle plus j cycles late.
module lane_skew #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         re_i,
    output logic [N-1:0] lane_en_o
);

    logic [N-1:0] sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= re_i;
            for (int j = 1; j < N; j++) begin
                sr_q[j] <= sr_q[j-1];
            end
        end
    end

    assign lane_en_o = sr_q;

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Tile controller: loads M*N words into the operand buffer, then
// streams M rows into the array with a per-lane skew.
module systolic_feed_ctrl
    import systolic_feed_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int D_2_W      = 2 * DATA_WIDTH,
    parameter int N          = 4,
    parameter int M          = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_feed_ctrl_if.slave  bus
);

    localparam int RW     = row_w(M);
    localparam int CW     = col_w(N);
    localparam int DRW    = drn_w(N);
    localparam int WORD_W = (D_2_W > 0) ? D_2_W : 2 * DATA_WIDTH;

    localparam logic [RW-1:0]  ROW_LAST = RW'(M - 1);
    localparam logic [CW-1:0]  COL_LAST = CW'(N - 1);
    localparam logic [DRW-1:0] DRN_LAST = DRW'(N - 1);

    state_e            state_q;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [DRW-1:0]    drn_q;
    logic              in_ready_q;
    logic              buf_we_q;
    logic              buf_re_q;
    logic              busy_q;
    logic              done_q;
    logic [WORD_W-1:0] wdata_q;
    logic [RW-1:0]     brow_q;
    logic [CW-1:0]     bcol_q;
    logic [N-1:0]      lane_en;
    logic              hs;
    logic              last_w;

    always_comb begin
        hs     = bus.in_valid & in_ready_q;
        last_w = (row_q == ROW_LAST) && (col_q == COL_LAST);
        col_d  = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        row_d  = (col_q == COL_LAST) ? row_q + 1'b1 : row_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            drn_q      <= '0;
            in_ready_q <= 1'b0;
            buf_we_q   <= 1'b0;
            buf_re_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wdata_q    <= '0;
            brow_q     <= '0;
            bcol_q     <= '0;
        end else begin
            buf_we_q <= 1'b0;
            done_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q    <= S_LOAD;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        row_q      <= '0;
                        col_q      <= '0;
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        buf_we_q <= 1'b1;
                        wdata_q  <= bus.in_data;
                        brow_q   <= row_q;
                        bcol_q   <= col_q;
                        row_q    <= row_d;
                        col_q    <= col_d;
                        if (last_w) begin
                            state_q    <= S_FEED;
                            in_ready_q <= 1'b0;
                            row_q      <= '0;
                            col_q      <= '0;
                        end
                    end
                end
                // First FEED cycle carries the final write, so reads start one cycle later.
                S_FEED: begin
                    if (buf_re_q && (brow_q == ROW_LAST)) begin
                        buf_re_q <= 1'b0;
                        state_q  <= S_DRAIN;
                        drn_q    <= '0;
                    end else begin
                        buf_re_q <= 1'b1;
                        brow_q   <= row_q;
                        if (row_q != ROW_LAST) begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drn_q == DRN_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        drn_q <= drn_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    lane_skew #(.N(N)) u_skew (
        .clk       (clk),
        .rst       (rst),
        .re_i      (buf_re_q),
        .lane_en_o (lane_en)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.buf_we    = buf_we_q;
    assign bus.buf_wdata = wdata_q;
    assign bus.buf_row   = brow_q;
    assign bus.buf_col   = bcol_q;
    assign bus.buf_re    = buf_re_q;
    assign bus.lane_en   = lane_en;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed and randomized tile sequences checked cycle by cycle
// against a timeline model of the feed controller.
module tb_systolic_feed_ctrl;

    localparam int N  = 4;
    localparam int M  = 7;
    localparam int DW = 32;

    logic clk;
    logic rst;

    systolic_feed_ctrl_if #(.D_2_W(DW), .N(N), .M(M)) bus ();

    systolic_feed_ctrl #(
        .DATA_WIDTH (16),
        .D_2_W      (DW),
        .N          (N),
        .M          (M)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    // mode: 0 idle, 1 loading, 2 all words in (reads/drain/done follow)
    int mode    = 0;
    int hs      = 0;
    int el      = 0;
    int start_e = 0;
    int n_we    = 0;
    int n_done  = 0;
    int done_c  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        chk({tag, "_buf_we"},   32'(bus.buf_we), 0);
        chk({tag, "_buf_re"},   32'(bus.buf_re), 0);
        chk({tag, "_lane_en"},  32'(bus.lane_en), 0);
        chk({tag, "_busy"},     32'(bus.busy), 0);
        chk({tag, "_done"},     32'(bus.done), 0);
        chk({tag, "_wdata"},    bus.buf_wdata, 0);
        chk({tag, "_row"},      32'(bus.buf_row), 0);
        chk({tag, "_col"},      32'(bus.buf_col), 0);
    endtask

    // One clock: drive inputs, advance the model at the edge, check at negedge.
    task automatic tick(input logic st, input logic v, input logic [DW-1:0] d);
        int          pre;
        int          rel;
        logic        e_we;
        logic        e_re;
        logic        e_done;
        logic        e_busy;
        logic [N-1:0] e_lane;
        logic [DW-1:0] e_d;
        int          e_r;
        int          e_c;
        bus.start    = st;
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        cyc++;
        pre  = mode;
        e_we = 1'b0;
        e_d  = '0;
        e_r  = 0;
        e_c  = 0;
        if (pre == 0 && st) begin
            mode    = 1;
            hs      = 0;
            start_e = cyc;
        end
        if (pre == 1 && v) begin
            e_we = 1'b1;
            e_d  = d;
            e_r  = hs / N;
            e_c  = hs % N;
            hs++;
            if (hs == M * N) begin
                mode = 2;
                el   = cyc;
            end
        end
        if (pre == 2 && cyc == el + M + N + 2) mode = 0;
        @(negedge clk);
        rel    = cyc - el;
        e_re   = (mode == 2) && rel >= 1 && rel <= M;
        e_done = (mode == 2) && rel == M + N + 1;
        e_busy = (mode == 1) || (mode == 2 && rel <= M + N);
        for (int j = 0; j < N; j++) begin
            e_lane[j] = (mode == 2) && rel >= 2 + j && rel <= 1 + M + j;
        end
        chk("in_ready", 32'(bus.in_ready), 32'(mode == 1));
        chk("buf_we", 32'(bus.buf_we), 32'(e_we));
        if (e_we) begin
            chk("wdata", bus.buf_wdata, e_d);
            chk("wr_row", 32'(bus.buf_row), 32'(e_r));
            chk("wr_col", 32'(bus.buf_col), 32'(e_c));
        end
        chk("buf_re", 32'(bus.buf_re), 32'(e_re));
        if (e_re) chk("rd_row", 32'(bus.buf_row), 32'(rel - 1));
        chk("lane_en", 32'(bus.lane_en), 32'(e_lane));
        chk("done", 32'(bus.done), 32'(e_done));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("we_re_excl", 32'(bus.buf_we & bus.buf_re), 0);
        if (bus.buf_we) n_we++;
        if (bus.done) begin
            n_done++;
            done_c = cyc;
        end
    endtask

    // vpat: 0 valid held high with data = word index, 1 toggling, 2 random.
    // poke: 0 none, 1 start pulse in the third FEED cycle, 2 random starts.
    task automatic run_tile(input int vpat, input int poke);
        logic          st;
        logic          v;
        logic [DW-1:0] d;
        int            krel;
        n_we   = 0;
        n_done = 0;
        tick(1'b1, 1'b0, '0);
        for (int k = 0; k < 3000 && mode != 0; k++) begin
            krel = cyc + 1 - start_e;
            case (vpat)
                0:       v = 1'b1;
                1:       v = krel[0];
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            d  = (vpat == 0) ? DW'(hs) : DW'($urandom);
            st = 1'b0;
            if (poke == 1 && mode == 2 && cyc + 1 == el + 3) st = 1'b1;
            if (poke == 2 && mode != 0) st = ($urandom_range(0, 7) == 0);
            tick(st, v, d);
        end
        chk("tile_end", 32'(mode), 0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // held-valid tile: 28 in-order writes, done 40 edges after start
        run_tile(0, 0);
        chk("t1_len", 32'(done_c - start_e), 40);
        chk("t1_writes", 32'(n_we), 28);
        chk("t1_done_n", 32'(n_done), 1);

        // toggled valid: last handshake 55 edges after start
        run_tile(1, 0);
        chk("t2_load_span", 32'(el - start_e), 55);
        chk("t2_len", 32'(done_c - start_e), 67);
        chk("t2_writes", 32'(n_we), 28);

        // stray start during FEED must not launch a second tile
        run_tile(2, 1);
        chk("t3_writes", 32'(n_we), 28);
        chk("t3_done_n", 32'(n_done), 1);
        repeat (5) tick(1'b0, 1'b1, DW'($urandom));
        chk("t3_extra_done", 32'(n_done), 1);

        // reset in the third FEED cycle aborts the tile
        n_done = 0;
        tick(1'b1, 1'b0, '0);
        for (int k = 0; k < 3000 && !(mode == 2 && cyc == el + 2); k++) begin
            tick(1'b0, 1'b1, DW'($urandom));
        end
        chk("t4_in_feed", 32'(mode == 2 && cyc == el + 2), 1);
        #2 rst = 1'b1;
        #1 chk_zero("rst_feed");
        mode = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk_zero("rst_hold");
        chk("t4_no_done", 32'(n_done), 0);
        rst = 1'b0;
        run_tile(0, 0);
        chk("t4_len", 32'(done_c - start_e), 40);
        chk("t4_done_n", 32'(n_done), 1);

        // random tiles with spurious starts
        for (int t = 0; t < 3; t++) begin
            run_tile(2, 2);
            chk("rnd_writes", 32'(n_we), 28);
            chk("rnd_done_n", 32'(n_done), 1);
            chk("rnd_len", 32'(done_c - el), 32'(M + N + 1));
            repeat ($urandom_range(0, 3)) tick(1'b0, 1'b0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
